// File: rtl/wrap_counter_bcd.sv
// wrap_counter_bcd: parametrised modulo counter with tick enable, up/down counting,
// range-checked parallel load, a one-cycle wrap pulse for cascading and registered
// BCD digits for the display driver. All outputs are registered.
//
// Parameters:
//   WIDTH     - width of count_out / load_val_in (2**WIDTH > MAX_VAL)
//   MIN_VAL   - lowest count value
//   MAX_VAL   - highest count value (MIN_VAL < MAX_VAL <= 99)
//   RESET_VAL - value loaded on reset (MIN_VAL <= RESET_VAL <= MAX_VAL)
//
// Ports:
//   clk_in       - clock, all state changes on rising edge
//   reset_in     - synchronous active-high reset
//   en_in        - count tick, one step per cycle while high
//   up_in        - direction, 1 = increment, 0 = decrement
//   load_in      - parallel load request (beats en_in)
//   load_val_in  - value to load
//   count_out    - current count, binary
//   tens_out     - BCD tens digit of count_out
//   ones_out     - BCD ones digit of count_out
//   wrap_out     - one-cycle pulse in the cycle the wrapped value first appears
//   load_err_out - one-cycle pulse after an out-of-range load request
module wrap_counter_bcd #(
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned MIN_VAL   = 0,
  parameter int unsigned MAX_VAL   = 59,
  parameter int unsigned RESET_VAL = MIN_VAL
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             en_in,
  input  logic             up_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_val_in,
  output logic [WIDTH-1:0] count_out,
  output logic [3:0]       tens_out,
  output logic [3:0]       ones_out,
  output logic             wrap_out,
  output logic             load_err_out
);

  localparam logic [WIDTH-1:0] MinV   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MaxV   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ResetV = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             below_min, above_max;
  logic [7:0]       count_ext;

  // Range bounds that coincide with the representable limits can never be violated;
  // tie those flags off instead of building always-constant comparators.
  if (MIN_VAL == 0) begin : g_no_min_chk
    assign below_min = 1'b0;
  end else begin : g_min_chk
    assign below_min = (load_val_in < MinV);
  end

  if (MAX_VAL == (2 ** WIDTH) - 1) begin : g_no_max_chk
    assign above_max = 1'b0;
  end else begin : g_max_chk
    assign above_max = (load_val_in > MaxV);
  end

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (reset_in) begin
      count_d = ResetV;
    end else if (load_in) begin
      if (below_min || above_max) begin
        load_err_d = 1'b1;
      end else begin
        count_d = load_val_in;
      end
    end else if (en_in) begin
      if (up_in) begin
        if (count_q == MaxV) begin
          count_d = MinV;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == MinV) begin
          count_d = MaxV;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // Digits come from the next-state value so they land on the same edge as the count.
  always_comb begin
    count_ext = 8'(count_d);
    tens_d    = 4'(count_ext / 8'd10);
    ones_d    = 4'(count_ext % 8'd10);
  end

  always_ff @(posedge clk_in) begin
    count_q    <= count_d;
    tens_q     <= tens_d;
    ones_q     <= ones_d;
    wrap_q     <= wrap_d;
    load_err_q <= load_err_d;
  end

  assign count_out    = count_q;
  assign tens_out     = tens_q;
  assign ones_out     = ones_q;
  assign wrap_out     = wrap_q;
  assign load_err_out = load_err_q;

endmodule

// File: tb/tb_wrap_counter_bcd.sv
// Directed testbench for wrap_counter_bcd using four instances:
//   h12: 1..12 reset 12, m60: 0..59, h24: 0..23, b2: 0..1.
module tb_wrap_counter_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // h12 instance
  logic h_rst = 0, h_en = 0, h_up = 0, h_ld = 0;
  logic [3:0] h_lv = 0, h_cnt, h_tens, h_ones;
  logic h_wrap, h_err;
  // m60 instance
  logic m_rst = 0, m_en = 0, m_up = 0, m_ld = 0;
  logic [6:0] m_lv = 0, m_cnt;
  logic [3:0] m_tens, m_ones;
  logic m_wrap, m_err;
  // h24 instance
  logic d_rst = 0, d_en = 0, d_up = 0, d_ld = 0;
  logic [4:0] d_lv = 0, d_cnt;
  logic [3:0] d_tens, d_ones;
  logic d_wrap, d_err;
  // b2 instance
  logic b_rst = 0, b_en = 0, b_up = 0, b_ld = 0;
  logic [0:0] b_lv = 0, b_cnt;
  logic [3:0] b_tens, b_ones;
  logic b_wrap, b_err;

  wrap_counter_bcd #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(12), .RESET_VAL(12)) u_h12 (
    .clk_in(clk), .reset_in(h_rst), .en_in(h_en), .up_in(h_up), .load_in(h_ld),
    .load_val_in(h_lv), .count_out(h_cnt), .tens_out(h_tens), .ones_out(h_ones),
    .wrap_out(h_wrap), .load_err_out(h_err));

  wrap_counter_bcd #(.WIDTH(7), .MIN_VAL(0), .MAX_VAL(59), .RESET_VAL(0)) u_m60 (
    .clk_in(clk), .reset_in(m_rst), .en_in(m_en), .up_in(m_up), .load_in(m_ld),
    .load_val_in(m_lv), .count_out(m_cnt), .tens_out(m_tens), .ones_out(m_ones),
    .wrap_out(m_wrap), .load_err_out(m_err));

  wrap_counter_bcd #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(23), .RESET_VAL(0)) u_h24 (
    .clk_in(clk), .reset_in(d_rst), .en_in(d_en), .up_in(d_up), .load_in(d_ld),
    .load_val_in(d_lv), .count_out(d_cnt), .tens_out(d_tens), .ones_out(d_ones),
    .wrap_out(d_wrap), .load_err_out(d_err));

  wrap_counter_bcd #(.WIDTH(1), .MIN_VAL(0), .MAX_VAL(1), .RESET_VAL(0)) u_b2 (
    .clk_in(clk), .reset_in(b_rst), .en_in(b_en), .up_in(b_up), .load_in(b_ld),
    .load_val_in(b_lv), .count_out(b_cnt), .tens_out(b_tens), .ones_out(b_ones),
    .wrap_out(b_wrap), .load_err_out(b_err));

  // Advance one edge and settle outputs away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    h_rst = 1; m_rst = 1; d_rst = 1; b_rst = 1;
    tick();
    h_rst = 0; m_rst = 0; d_rst = 0; b_rst = 0;
    checks++; if (h_cnt !== 4'd12) begin errors++; $display("FAIL reset_cnt got %0d want 12", h_cnt); end
    checks++; if (h_tens !== 4'd1) begin errors++; $display("FAIL reset_tens got %0d want 1", h_tens); end
    checks++; if (h_ones !== 4'd2) begin errors++; $display("FAIL reset_ones got %0d want 2", h_ones); end
    checks++; if (h_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", h_wrap); end
    checks++; if (h_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", h_err); end
    checks++; if (m_cnt !== 7'd0) begin errors++; $display("FAIL reset_m60 got %0d want 0", m_cnt); end
  endtask

  task automatic test_up_wrap();
    h_ld = 1; h_lv = 4'd11;
    tick();
    h_ld = 0;
    checks++; if (h_cnt !== 4'd11) begin errors++; $display("FAIL up_load got %0d want 11", h_cnt); end
    h_en = 1; h_up = 1;
    tick();
    checks++; if (h_cnt !== 4'd12 || h_wrap !== 1'b0) begin
      errors++; $display("FAIL up_12 got %0d/%b want 12/0", h_cnt, h_wrap); end
    tick();
    h_en = 0;
    checks++; if (h_cnt !== 4'd1 || h_wrap !== 1'b1) begin
      errors++; $display("FAIL up_wrap got %0d/%b want 1/1", h_cnt, h_wrap); end
    checks++; if (h_tens !== 4'd0 || h_ones !== 4'd1) begin
      errors++; $display("FAIL up_wrap_bcd got %0d%0d want 01", h_tens, h_ones); end
    tick();
    checks++; if (h_cnt !== 4'd1 || h_wrap !== 1'b0) begin
      errors++; $display("FAIL up_idle got %0d/%b want 1/0", h_cnt, h_wrap); end
  endtask

  task automatic test_down_wrap();
    m_en = 1; m_up = 0;
    tick();
    checks++; if (m_cnt !== 7'd59 || m_wrap !== 1'b1) begin
      errors++; $display("FAIL down_wrap got %0d/%b want 59/1", m_cnt, m_wrap); end
    checks++; if (m_tens !== 4'd5 || m_ones !== 4'd9) begin
      errors++; $display("FAIL down_bcd got %0d%0d want 59", m_tens, m_ones); end
    tick();
    checks++; if (m_cnt !== 7'd58 || m_wrap !== 1'b0) begin
      errors++; $display("FAIL down_58 got %0d/%b want 58/0", m_cnt, m_wrap); end
    m_up = 1;  // direction change applies on the very next tick
    tick();
    checks++; if (m_cnt !== 7'd59 || m_wrap !== 1'b0) begin
      errors++; $display("FAIL dir_change got %0d/%b want 59/0", m_cnt, m_wrap); end
    tick();
    m_en = 0;
    checks++; if (m_cnt !== 7'd0 || m_wrap !== 1'b1 || m_tens !== 4'd0 || m_ones !== 4'd0) begin
      errors++; $display("FAIL up_wrap59 got %0d/%b want 0/1", m_cnt, m_wrap); end
  endtask

  task automatic test_load_err();
    d_ld = 1; d_lv = 5'd7;
    tick();
    checks++; if (d_cnt !== 5'd7) begin errors++; $display("FAIL ld7 got %0d want 7", d_cnt); end
    d_lv = 5'd24; d_en = 1; d_up = 1;
    tick();
    checks++; if (d_cnt !== 5'd7 || d_err !== 1'b1 || d_wrap !== 1'b0) begin
      errors++; $display("FAIL ld_err got %0d/%b/%b want 7/1/0", d_cnt, d_err, d_wrap); end
    d_lv = 5'd23; d_en = 0;
    tick();
    checks++; if (d_cnt !== 5'd23 || d_err !== 1'b0) begin
      errors++; $display("FAIL ld23 got %0d/%b want 23/0", d_cnt, d_err); end
    checks++; if (d_tens !== 4'd2 || d_ones !== 4'd3) begin
      errors++; $display("FAIL ld23_bcd got %0d%0d want 23", d_tens, d_ones); end
    tick();  // same-value load is valid
    d_ld = 0;
    checks++; if (d_cnt !== 5'd23 || d_err !== 1'b0 || d_wrap !== 1'b0) begin
      errors++; $display("FAIL ld_same got %0d/%b/%b want 23/0/0", d_cnt, d_err, d_wrap); end
    h_ld = 1; h_lv = 4'd0;  // below MIN_VAL=1
    tick();
    h_ld = 0;
    checks++; if (h_cnt !== 4'd1 || h_err !== 1'b1) begin
      errors++; $display("FAIL ld_below got %0d/%b want 1/1", h_cnt, h_err); end
    h_ld = 1; h_lv = 4'd13;
    tick();
    h_ld = 0;
    checks++; if (h_cnt !== 4'd1 || h_err !== 1'b1) begin
      errors++; $display("FAIL ld_above got %0d/%b want 1/1", h_cnt, h_err); end
    tick();
    checks++; if (h_err !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", h_err); end
  endtask

  task automatic test_load_priority();
    m_ld = 1; m_lv = 7'd59;
    tick();
    m_lv = 7'd30; m_en = 1; m_up = 1;
    tick();
    m_ld = 0; m_en = 0;
    checks++; if (m_cnt !== 7'd30 || m_wrap !== 1'b0) begin
      errors++; $display("FAIL ld_prio got %0d/%b want 30/0", m_cnt, m_wrap); end
    checks++; if (m_tens !== 4'd3 || m_ones !== 4'd0) begin
      errors++; $display("FAIL ld_prio_bcd got %0d%0d want 30", m_tens, m_ones); end
  endtask

  task automatic test_reset_priority();
    m_ld = 1; m_lv = 7'd45;
    tick();
    m_ld = 0;
    m_rst = 1; m_en = 1; m_up = 1;
    tick();
    m_rst = 0;
    checks++; if (m_cnt !== 7'd0 || m_wrap !== 1'b0 || m_err !== 1'b0) begin
      errors++; $display("FAIL rst_prio got %0d/%b/%b want 0/0/0", m_cnt, m_wrap, m_err); end
    tick();
    checks++; if (m_cnt !== 7'd1) begin errors++; $display("FAIL rst_resume got %0d want 1", m_cnt); end
    // A pending wrap pulse is cleared by reset.
    m_en = 0; m_ld = 1; m_lv = 7'd59;
    tick();
    m_ld = 0; m_en = 1;
    tick();
    checks++; if (m_wrap !== 1'b1 || m_cnt !== 7'd0) begin
      errors++; $display("FAIL pre_rst_wrap got %0d/%b want 0/1", m_cnt, m_wrap); end
    m_rst = 1; m_ld = 1; m_lv = 7'd70;
    tick();
    m_rst = 0; m_ld = 0; m_en = 0;
    checks++; if (m_wrap !== 1'b0 || m_err !== 1'b0 || m_cnt !== 7'd0) begin
      errors++; $display("FAIL rst_clear got %0d/%b/%b want 0/0/0", m_cnt, m_wrap, m_err); end
  endtask

  task automatic test_back_to_back();
    logic [0:0] exp_cnt;
    logic       exp_wrap;
    exp_cnt = 1'b0;
    b_en = 1; b_up = 1;
    for (int i = 0; i < 4; i++) begin
      exp_wrap = (exp_cnt == 1'b1);
      exp_cnt  = ~exp_cnt;
      tick();
      checks++; if (b_cnt !== exp_cnt || b_wrap !== exp_wrap) begin
        errors++; $display("FAIL b2b_%0d got %0d/%b want %0d/%b", i, b_cnt, b_wrap, exp_cnt, exp_wrap);
      end
    end
    b_en = 0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_err();
    test_load_priority();
    test_reset_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
